// File: rtl/uart_frame_tx.sv
// uart_frame_tx: framed serial transmitter for the SerialComm link.
// Sends start bit (0), eight data bits LSB first, optional even parity and
// STOP_BITS stop bits (1). One bit lasts CLKS_PER_BIT cycles of clock.
// Compile-time option: define UART_TX_PARITY_EN to insert the even-parity bit.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | nothing held, line high, load captures a byte
// READY  | byte held, line high, waiting for transmit_enable
// START  | start bit (line low) for one bit period
// DATA   | data bits shreg[0..7], one bit period each
// PARITY | even parity over the held byte (UART_TX_PARITY_EN only)
// STOP   | line high for STOP_BITS bit periods, then IDLE or READY
//
// serial_out is registered from the current state, so the line follows the
// state register by one clock. char_sent is decoded from registers and marks
// the last STOP clock, which is also the clock where a new load is accepted.

module uart_frame_tx #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int CNT_W        = 13,
  parameter int STOP_BITS    = 1
) (
  input  logic       clock,
  input  logic       rst,
  input  logic [7:0] parallel_in,
  input  logic       load,
  input  logic       transmit_enable,
  output logic       serial_out,
  output logic       busy,
  output logic       char_sent
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READY  = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd4,
`endif
    STOP   = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  // Index of the final stop bit: 0 for one stop bit, 1 for two.
  localparam logic             STOP_LAST = (STOP_BITS == 2);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             stop_q, stop_d;
  logic             tx_bit;
  logic             bit_end;
  logic             timed;

  assign bit_end = (cnt_q == BIT_LAST);

  // States that run the bit-period counter; it rests at 0 elsewhere so that
  // entry to START always begins a full bit period.
  assign timed = (state_q == START) || (state_q == DATA) ||
`ifdef UART_TX_PARITY_EN
                 (state_q == PARITY) ||
`endif
                 (state_q == STOP);

  // Last clock of the last stop bit.
  assign char_sent = (state_q == STOP) && bit_end && (stop_q == STOP_LAST);

  // Next-state, datapath updates and the line value for the current state.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    stop_d  = stop_q;
    tx_bit  = 1'b1;

    if (timed) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (load) begin
          shreg_d = parallel_in;
          state_d = READY;
        end
      end

      READY: begin
        if (transmit_enable) begin
          state_d = START;
          cnt_d   = '0;
          idx_d   = 3'd0;
          stop_d  = 1'b0;
        end
      end

      START: begin
        tx_bit = 1'b0;
        if (bit_end) begin
          state_d = DATA;
        end
      end

      DATA: begin
        tx_bit = shreg_q[idx_q];
        if (bit_end) begin
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_bit = ^shreg_q;
        if (bit_end) begin
          state_d = STOP;
        end
      end
`endif

      STOP: begin
        tx_bit = 1'b1;
        if (bit_end) begin
          if (stop_q == STOP_LAST) begin
            // A byte offered on the final stop clock goes straight to READY,
            // giving back-to-back frames with a single idle-high clock between.
            if (load) begin
              shreg_d = parallel_in;
              state_d = READY;
            end else begin
              state_d = IDLE;
            end
          end else begin
            stop_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs; reset drops any frame in flight.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= 3'd0;
      shreg_q    <= 8'h00;
      stop_q     <= 1'b0;
      serial_out <= 1'b1;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shreg_q    <= shreg_d;
      stop_q     <= stop_d;
      serial_out <= tx_bit;
      busy       <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx with CLKS_PER_BIT=4, STOP_BITS=1.
// Honours UART_TX_PARITY_EN when the design is built with it.

module tb_uart_frame_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  logic       clock = 1'b0;
  logic       rst;
  logic [7:0] parallel_in;
  logic       load;
  logic       transmit_enable;
  logic       serial_out;
  logic       busy;
  logic       char_sent;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  uart_frame_tx #(
    .CLKS_PER_BIT(CPB),
    .CNT_W(4),
    .STOP_BITS(1)
  ) dut (
    .clock(clock),
    .rst(rst),
    .parallel_in(parallel_in),
    .load(load),
    .transmit_enable(transmit_enable),
    .serial_out(serial_out),
    .busy(busy),
    .char_sent(char_sent)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // Called at the first clock of the start bit on the line. Checks every
  // line clock of the frame and the single char_sent pulse, optionally
  // driving load during a window of frame clocks.
  task automatic send_frame(input string tag, input logic [7:0] data, input logic par,
                            input int load_from, input int load_to, input logic [7:0] load_data);
    logic [10:0] vec;
    int pulses;
    pulses = 0;
    vec = {1'b1, par, data, 1'b0};
    for (int j = 0; j < FRAME; j++) begin
      int bi;
      bi = j / CPB;
`ifndef UART_TX_PARITY_EN
      if (bi == 9) bi = 10;
`endif
      chk({tag, "_bit"}, {7'd0, serial_out}, {7'd0, vec[bi]});
      chk({tag, "_char"}, {7'd0, char_sent}, {7'd0, (j == FRAME - 2)});
      if (char_sent) pulses++;
      load = (j >= load_from) && (j <= load_to);
      if (load) parallel_in = load_data;
      step();
    end
    chk({tag, "_pulses"}, 8'(pulses), 8'd1);
  endtask

  initial begin
    #1_000_000;
    $error("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int pulses;
    rst = 1'b1;
    load = 1'b0;
    transmit_enable = 1'b0;
    parallel_in = 8'h00;

    // Reset state, then idle with no load.
    step();
    step();
    chk("rst_serial", {7'd0, serial_out}, 8'd1);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_char", {7'd0, char_sent}, 8'd0);
    rst = 1'b0;
    repeat (3) step();
    chk("idle_serial", {7'd0, serial_out}, 8'd1);
    chk("idle_busy", {7'd0, busy}, 8'd0);
    chk("idle_char", {7'd0, char_sent}, 8'd0);

    // Reset and load together: nothing captured.
    rst = 1'b1;
    load = 1'b1;
    parallel_in = 8'h3C;
    transmit_enable = 1'b1;
    step();
    rst = 1'b0;
    load = 1'b0;
    step();
    step();
    chk("rstload_busy", {7'd0, busy}, 8'd0);
    chk("rstload_serial", {7'd0, serial_out}, 8'd1);

    // 0xA5 with transmit_enable already high: line falls two clocks after load.
    parallel_in = 8'hA5;
    load = 1'b1;
    step();
    chk("a5_accept_busy", {7'd0, busy}, 8'd1);
    chk("a5_accept_serial", {7'd0, serial_out}, 8'd1);
    load = 1'b0;
    step();
    chk("a5_lat_serial", {7'd0, serial_out}, 8'd1);
    step();
    send_frame("a5", 8'hA5, 1'b0, -1, -1, 8'h00);
    chk("a5_end_busy", {7'd0, busy}, 8'd0);
    chk("a5_end_serial", {7'd0, serial_out}, 8'd1);

    // 0x3C held in READY until transmit_enable rises.
    transmit_enable = 1'b0;
    parallel_in = 8'h3C;
    load = 1'b1;
    step();
    load = 1'b0;
    repeat (8) step();
    chk("3c_hold_busy", {7'd0, busy}, 8'd1);
    chk("3c_hold_serial", {7'd0, serial_out}, 8'd1);
    chk("3c_hold_char", {7'd0, char_sent}, 8'd0);
    transmit_enable = 1'b1;
    step();
    chk("3c_en_serial", {7'd0, serial_out}, 8'd1);
    step();
    send_frame("3c", 8'h3C, 1'b0, -1, -1, 8'h00);
    chk("3c_end_busy", {7'd0, busy}, 8'd0);

    // Load of 0xFF during DATA is ignored.
    parallel_in = 8'hA5;
    load = 1'b1;
    step();
    load = 1'b0;
    step();
    step();
    send_frame("ign", 8'hA5, 1'b0, 12, 12, 8'hFF);
    chk("ign_end_busy", {7'd0, busy}, 8'd0);
    repeat (4) step();
    chk("ign_after_busy", {7'd0, busy}, 8'd0);
    chk("ign_after_serial", {7'd0, serial_out}, 8'd1);

    // load held through a frame: 0x55 captured on the char_sent clock.
    parallel_in = 8'hA5;
    load = 1'b1;
    step();
    parallel_in = 8'h55;
    step();
    step();
    send_frame("b2b1", 8'hA5, 1'b0, 0, FRAME - 1, 8'h55);
    load = 1'b0;
    chk("b2b_gap_serial", {7'd0, serial_out}, 8'd1);
    chk("b2b_gap_busy", {7'd0, busy}, 8'd1);
    step();
    send_frame("b2b2", 8'h55, 1'b0, -1, -1, 8'h00);
    chk("b2b_end_busy", {7'd0, busy}, 8'd0);

    // Reset during DATA bit 3 of 0xA5.
    parallel_in = 8'hA5;
    load = 1'b1;
    step();
    load = 1'b0;
    step();
    step();
    repeat (18) step();
    chk("mid_bit3", {7'd0, serial_out}, 8'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_serial", {7'd0, serial_out}, 8'd1);
    chk("mid_rst_busy", {7'd0, busy}, 8'd0);
    chk("mid_rst_char", {7'd0, char_sent}, 8'd0);
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      if (char_sent || busy || !serial_out) pulses++;
      step();
    end
    chk("mid_rst_quiet", 8'(pulses), 8'd0);

    // 0x07 after reset: odd number of ones.
    parallel_in = 8'h07;
    load = 1'b1;
    step();
    load = 1'b0;
    step();
    step();
    send_frame("07", 8'h07, 1'b1, -1, -1, 8'h00);
    chk("07_end_busy", {7'd0, busy}, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
